// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared types for the I2C command sequencer slice.
//   seq_state_t      : sequencer FSM states
//   i2c_cmd_t        : one queued single-byte transaction {rw, addr, data}
//   I2C_TIMEOUT_DATA : byte returned on a watchdog-terminated transaction
// ----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } i2c_cmd_t;

    localparam logic [7:0] I2C_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// ----------------------------------------------------------------------------
// i2c_cmd_fifo
// Synchronous FIFO of i2c_cmd_t entries with a combinational head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (flushes the FIFO)
//   push      : write wr_cmd (ignored when full, even if popping)
//   wr_cmd    : entry to write
//   pop       : drop the head entry (ignored when empty)
//   full      : no free entries
//   empty     : no valid entries
//   head      : oldest entry
// ----------------------------------------------------------------------------
module i2c_cmd_fifo
    import i2c_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  i2c_cmd_t wr_cmd,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output i2c_cmd_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    i2c_cmd_t    mem [DEPTH];

    // Full when the wrap bits differ but the index bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_cmd;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_cmd_sequencer
// Queues single-byte I2C transactions and launches them one at a time on the
// driver's start/busy handshake; read bytes come back on a valid/ready port.
// Optional watchdog: define I2C_SEQ_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES and return I2C_TIMEOUT_DATA with rsp_timeout set.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_valid/cmd_ready            : command push handshake (ready = !full)
//   cmd_rw/cmd_addr/cmd_data       : command fields (data ignored for reads)
//   rsp_valid/rsp_ready            : response handshake
//   rsp_data/rsp_timeout           : read byte / watchdog flag
//   drv_start                      : one-cycle start pulse to the driver
//   drv_rw/drv_addr/drv_data       : transaction fields held until done
//   drv_busy/drv_rdata             : driver status and read data
//   idle                           : FIFO empty and FSM idle
// ----------------------------------------------------------------------------
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       drv_start,
    output logic       drv_rw,
    output logic [6:0] drv_addr,
    output logic [7:0] drv_data,
    input  logic       drv_busy,
    input  logic [7:0] drv_rdata,
    output logic       idle
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("i2c_cmd_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES 1..65535");
    end

    seq_state_t state;
    i2c_cmd_t   in_cmd;
    i2c_cmd_t   head;
    logic       full;
    logic       empty;
    logic       pop;
    logic       done_now;
    logic       to_fire;

    assign in_cmd    = {cmd_rw, cmd_addr, cmd_data};
    assign cmd_ready = !full;
    assign drv_start = (state == ST_LAUNCH);
    assign idle      = empty && (state == ST_IDLE);

    // Driver finished this cycle; this beats a simultaneous watchdog expiry.
    assign done_now = (state == ST_WAIT_DONE) && !drv_busy;

    // The head is popped once the driver acknowledges with busy, or when the
    // watchdog gives up before busy was ever seen.
    assign pop = (state == ST_WAIT_BUSY) && (drv_busy || to_fire);

    i2c_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (cmd_valid),
        .wr_cmd (in_cmd),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;

    // Counts cycles spent waiting on the driver; restarts at every launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ST_LAUNCH) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT_BUSY || state == ST_WAIT_DONE) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign to_fire = (state == ST_WAIT_BUSY || state == ST_WAIT_DONE) &&
                     (to_cnt == TIMEOUT_LAST) && !done_now;

    // Flag only changes when a new response is loaded, so it stays stable
    // while rsp_valid waits for rsp_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_timeout <= 1'b0;
        end else if (to_fire) begin
            rsp_timeout <= 1'b1;
        end else if (done_now && drv_rw) begin
            rsp_timeout <= 1'b0;
        end
    end
`else
    assign to_fire     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Main sequencer: launch from the FIFO head only when the response slot
    // is free, so a read result can never be overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drv_rw    <= 1'b0;
            drv_addr  <= '0;
            drv_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!empty && !rsp_valid) begin
                        state    <= ST_LAUNCH;
                        drv_rw   <= head.rw;
                        drv_addr <= head.addr;
                        drv_data <= head.data;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (to_fire) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= I2C_TIMEOUT_DATA;
                    end else if (drv_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_now) begin
                        state <= ST_IDLE;
                        if (drv_rw) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= drv_rdata;
                        end
                    end else if (to_fire) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= I2C_TIMEOUT_DATA;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
